// File: rtl/sumador_multiciclo.sv
// Multi-cycle W-bit adder/subtractor: one C-bit adder reused over K = W/C cycles,
// least-significant chunk first, with a registered carry linking the chunks.
module sumadorNbits #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module sumador_multiciclo #(
  parameter int W = 64,
  parameter int C = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic         cout,
  output logic         ovf
);
  localparam int K  = W / C;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   r_sh_q, r_sh_d;
  logic [W-1:0]   q_q, q_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [C-1:0]   sum;
  logic           sum_cout;
  logic [W-1:0]   sum_wide;
  logic [W-1:0]   r_shifted;
  logic [W-1:0]   b_eff;

  sumadorNbits #(.N(C)) u_add (
    .a    (a_sh_q[C-1:0]),
    .b    (b_sh_q[C-1:0]),
    .cin  (carry_q),
    .s    (sum),
    .cout (sum_cout)
  );

  // Written as shift-and-OR so the single-chunk case (C == W) needs no special slice.
  always_comb begin
    sum_wide          = '0;
    sum_wide[C-1:0]   = sum;
    r_shifted         = (r_sh_q >> C) | (sum_wide << (W - C));
    b_eff             = sub ? ~b : b;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    q_d     = q_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_eff;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          a_msb_d = a[W-1];
          b_msb_d = b_eff[W-1];
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = sum_cout;
        a_sh_d  = a_sh_q >> C;
        b_sh_d  = b_sh_q >> C;
        r_sh_d  = r_shifted;
        idx_d   = idx_q + 1'b1;
        // Last chunk: its sum bit C-1 is the result's sign bit.
        if (idx_q == IW'(K - 1)) begin
          q_d     = r_shifted;
          cout_d  = sum_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (sum[C-1] != a_msb_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      q_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign q    = q_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_sumador_multiciclo.sv
// Bench for sumador_multiciclo: a whole-word arithmetic model compared every cycle,
// plus directed vectors with hand-computed results for a 64/16 and an 8/8 instance.
module tb_sumador_multiciclo;
  localparam int W = 64;
  localparam int C = 16;
  localparam int K = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] q;

  logic         s_start = 1'b0;
  logic [7:0]   s_a = '0;
  logic [7:0]   s_b = '0;
  logic         s_cin = 1'b0;
  logic         s_sub = 1'b0;
  logic         s_busy, s_done, s_cout, s_ovf;
  logic [7:0]   s_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sumador_multiciclo #(.W(W), .C(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .q(q), .cout(cout), .ovf(ovf)
  );

  sumador_multiciclo #(.W(8), .C(8)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
    .busy(s_busy), .done(s_done), .q(s_q), .cout(s_cout), .ovf(s_ovf)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Returns {cout, ovf, q} for the whole-word operation.
  function automatic logic [W+1:0] addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic sb);
    logic [W-1:0] ye;
    logic [W:0]   s;
    logic         v;
    ye = sb ? ~y : y;
    s  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    v  = (x[W-1] == ye[W-1]) && (s[W-1] != x[W-1]);
    return {s[W], v, s[W-1:0]};
  endfunction

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W+1:0] m_pend = '0;
  int           m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
      m_q    <= '0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == K) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_cout <= m_pend[W+1];
        m_ovf  <= m_pend[W];
        m_q    <= m_pend[W-1:0];
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= addsub(a, b, cin, sub);
        m_busy <= 1'b1;
        m_cnt  <= 1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model_busy", 64'(busy), 64'(m_busy));
    checkOutput("model_done", 64'(done), 64'(m_done));
    checkOutput("model_q",    q,         m_q);
    checkOutput("model_cout", 64'(cout), 64'(m_cout));
    checkOutput("model_ovf",  64'(ovf),  64'(m_ovf));
  end

  // Leaves the bench at the first negedge after the accepting edge, start low.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tsub);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int first, output int cyc, output int bcnt);
    cyc  = first;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (!done) checkOutput("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int cyc, bcnt;
    logic saw_done;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_q",    q,         64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_ovf",  64'(ovf),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    waitDone(1, cyc, bcnt);
    checkOutput("ripple_latency", 64'(cyc), 64'd5);
    checkOutput("ripple_busy_cycles", 64'(bcnt), 64'd4);
    checkOutput("ripple_q", q, 64'h0);
    checkOutput("ripple_cout", 64'(cout), 64'd1);
    checkOutput("ripple_ovf", 64'(ovf), 64'd0);

    applyStimulus(64'd5, 64'd7, 1'b1, 1'b1);
    waitDone(1, cyc, bcnt);
    checkOutput("borrow_q", q, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("borrow_cout", 64'(cout), 64'd0);
    checkOutput("borrow_ovf", 64'(ovf), 64'd0);

    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    waitDone(1, cyc, bcnt);
    checkOutput("ovf_add_q", q, 64'h8000_0000_0000_0000);
    checkOutput("ovf_add_ovf", 64'(ovf), 64'd1);
    checkOutput("ovf_add_cout", 64'(cout), 64'd0);

    applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    waitDone(1, cyc, bcnt);
    checkOutput("ovf_sub_q", q, 64'h7FFF_FFFF_FFFF_FFFF);
    checkOutput("ovf_sub_ovf", 64'(ovf), 64'd1);
    checkOutput("ovf_sub_cout", 64'(cout), 64'd1);

    // A start pulse in the middle of RUN must not disturb the operation in flight.
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    a = 64'd5; b = 64'd5; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(3, cyc, bcnt);
    checkOutput("midstart_latency", 64'(cyc), 64'd5);
    checkOutput("midstart_q", q, 64'h1234_5678_9ABC_DF00);
    checkOutput("midstart_cout", 64'(cout), 64'd0);

    applyStimulus(64'd3, 64'd4, 1'b0, 1'b0);
    waitDone(1, cyc, bcnt);
    checkOutput("b2b_first_q", q, 64'd7);
    a = 64'd0; b = 64'd0; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      checkOutput("b2b_hold_q", q, 64'd7);
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_latency", 64'(cyc), 64'd5);
    checkOutput("b2b_second_q", q, 64'd1);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_q", q, 64'd0);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    checkOutput("midrst_no_done", 64'(saw_done), 64'd0);
    applyStimulus(64'd1234, 64'd1, 1'b0, 1'b0);
    waitDone(1, cyc, bcnt);
    checkOutput("after_rst_latency", 64'(cyc), 64'd5);
    checkOutput("after_rst_q", q, 64'd1235);
    checkOutput("after_rst_cout", 64'(cout), 64'd0);

    @(negedge clk);
    s_a = 8'hFF; s_b = 8'h01; s_cin = 1'b0; s_sub = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 1;
    while (!s_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("small_latency", 64'(cyc), 64'd2);
    checkOutput("small_q", 64'(s_q), 64'h00);
    checkOutput("small_cout", 64'(s_cout), 64'd1);
    checkOutput("small_ovf", 64'(s_ovf), 64'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
